// File: rtl/kernel_seq_ctrl.sv
// Kernel weight register file sequencer: LOAD writes N weights, RUN replays N taps for P passes.
// Starts take effect the cycle after sampling; one write or tap per cycle; w_valid gaps and tap_ready stall in place.
module kernel_seq_ctrl #(
    parameter int KERNEL_REG_SIZE   = 64,
    parameter int KERNEL_ADDR_WIDTH = 6,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int PASS_WIDTH        = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [KERNEL_ADDR_WIDTH:0]   cfg_num_taps,
    input  logic [PASS_WIDTH-1:0]        cfg_num_passes,
    input  logic                         load_start,
    input  logic                         run_start,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [WEIGHT_WIDTH-1:0]      w_data,
    output logic                         kr_wr_en,
    output logic [KERNEL_ADDR_WIDTH-1:0] kr_wr_addr,
    output logic [WEIGHT_WIDTH-1:0]      kr_wr_data,
    output logic [KERNEL_ADDR_WIDTH-1:0] kr_rd_addr,
    output logic                         tap_valid,
    input  logic                         tap_ready,
    output logic                         tap_first,
    output logic                         tap_last,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int NW = KERNEL_ADDR_WIDTH + 1;
    localparam logic [NW-1:0]         LP_SIZE = NW'(KERNEL_REG_SIZE);
    localparam logic [NW-1:0]         LP_N1   = NW'(1);
    localparam logic [PASS_WIDTH-1:0] LP_P1   = PASS_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t                       r_state, w_next;
    logic [NW-1:0]                r_n, r_loaded_n;
    logic [PASS_WIDTH-1:0]        r_p, r_pass_cnt;
    logic [KERNEL_ADDR_WIDTH-1:0] r_wr_idx, r_rd_idx;
    logic                         r_loaded, r_err;

    logic w_idle, w_n_bad, w_run_bad, w_acc_load, w_acc_run, w_reject;
    logic w_wr_hs, w_wr_last, w_rd_hs, w_rd_last, w_pass_last;

    assign w_idle     = (r_state == S_IDLE);
    assign w_n_bad    = (cfg_num_taps == '0) || (cfg_num_taps > LP_SIZE);
    assign w_run_bad  = !r_loaded || (cfg_num_passes == '0) || (cfg_num_taps > r_loaded_n);
    // load_start has priority, so a bad load is rejected even if the run alone would be legal
    assign w_acc_load = w_idle && load_start && !w_n_bad;
    assign w_acc_run  = w_idle && !load_start && run_start && !w_n_bad && !w_run_bad;
    assign w_reject   = w_idle && (load_start || run_start) && !w_acc_load && !w_acc_run;

    assign w_wr_hs     = (r_state == S_LOAD) && w_valid;
    assign w_wr_last   = ({1'b0, r_wr_idx} == (r_n - LP_N1));
    assign w_rd_hs     = (r_state == S_RUN) && tap_ready;
    assign w_rd_last   = ({1'b0, r_rd_idx} == (r_n - LP_N1));
    assign w_pass_last = (r_pass_cnt == (r_p - LP_P1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc_load)     w_next = S_LOAD;
                else if (w_acc_run) w_next = S_RUN;
            end
            S_LOAD:  if (w_wr_hs && w_wr_last) w_next = S_DONE;
            S_RUN:   if (w_rd_hs && w_rd_last && w_pass_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_p        <= '0;
            r_loaded_n <= '0;
            r_pass_cnt <= '0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_loaded   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_reject;
            if (w_acc_load || w_acc_run) begin
                r_n        <= cfg_num_taps;
                r_p        <= cfg_num_passes;
                r_wr_idx   <= '0;
                r_rd_idx   <= '0;
                r_pass_cnt <= '0;
            end
            if (w_acc_load) r_loaded <= 1'b0;
            if (w_wr_hs) begin
                r_wr_idx <= r_wr_idx + 1'b1;
                if (w_wr_last) begin
                    r_loaded   <= 1'b1;
                    r_loaded_n <= r_n;
                end
            end
            if (w_rd_hs) begin
                if (w_rd_last) begin
                    r_rd_idx   <= '0;
                    r_pass_cnt <= r_pass_cnt + 1'b1;
                end else begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                end
            end
        end
    end

    assign w_ready    = (r_state == S_LOAD);
    assign kr_wr_en   = w_wr_hs;
    assign kr_wr_addr = r_wr_idx;
    assign kr_wr_data = w_ready ? w_data : '0;
    assign kr_rd_addr = r_rd_idx;
    assign tap_valid  = (r_state == S_RUN);
    assign tap_first  = tap_valid && (r_rd_idx == '0);
    assign tap_last   = tap_valid && w_rd_last;
    assign busy       = !w_idle;
    assign done       = (r_state == S_DONE);
    assign err        = r_err;

endmodule

// File: tb/tb_kernel_seq_ctrl.sv
// Directed bench for kernel_seq_ctrl with a behavioural kernel register file alongside.
module tb_kernel_seq_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [6:0] cfg_num_taps = '0;
    logic [15:0] cfg_num_passes = '0;
    logic       load_start = 1'b0, run_start = 1'b0;
    logic       w_valid = 1'b0, w_ready;
    logic [7:0] w_data = '0;
    logic       kr_wr_en;
    logic [5:0] kr_wr_addr, kr_rd_addr;
    logic [7:0] kr_wr_data, rd_data;
    logic       tap_valid, tap_ready = 1'b0, tap_first, tap_last;
    logic       busy, done, err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mem [64];
    int wr_count = 0;

    kernel_seq_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .cfg_num_taps(cfg_num_taps), .cfg_num_passes(cfg_num_passes),
        .load_start(load_start), .run_start(run_start),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .kr_wr_en(kr_wr_en), .kr_wr_addr(kr_wr_addr), .kr_wr_data(kr_wr_data),
        .kr_rd_addr(kr_rd_addr), .tap_valid(tap_valid), .tap_ready(tap_ready),
        .tap_first(tap_first), .tap_last(tap_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (kr_wr_en) begin
            mem[kr_wr_addr] <= kr_wr_data;
            wr_count        <= wr_count + 1;
        end
    end
    assign rd_data = mem[kr_rd_addr];

    task automatic start(input logic ld, input logic rn, input int n, input int p);
        @(negedge i_clk);
        load_start     = ld;
        run_start      = rn;
        cfg_num_taps   = 7'(n);
        cfg_num_passes = 16'(p);
        @(negedge i_clk);
        load_start = 1'b0;
        run_start  = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge i_clk);
        #1;
        n_checks++;
        if ({w_ready, kr_wr_en, tap_valid, tap_first, tap_last, busy, done, err} !== 8'h00)
            $display("FAIL reset_flags got %b want 00000000",
                     {w_ready, kr_wr_en, tap_valid, tap_first, tap_last, busy, done, err});
        else n_pass++;
        n_checks++;
        if ({kr_wr_addr, kr_rd_addr, kr_wr_data} !== 20'h0)
            $display("FAIL reset_addr got %h want 0", {kr_wr_addr, kr_rd_addr, kr_wr_data});
        else n_pass++;
        i_rst = 1'b0;
    endtask

    // Table of rejected starts: run unloaded, N=0, N=65, run N>loaded_n, P=0.
    task automatic test_errors(input int lo, input int hi);
        logic ld_t [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int   n_t  [5] = '{9, 0, 65, 10, 9};
        int   p_t  [5] = '{1, 1, 1, 1, 0};
        for (int i = lo; i <= hi; i++) begin
            int w0 = wr_count;
            start(ld_t[i], !ld_t[i], n_t[i], p_t[i]);
            #1;
            n_checks++;
            if ({err, busy} !== 2'b10)
                $display("FAIL err_pulse case%0d got err/busy=%b want 10", i, {err, busy});
            else n_pass++;
            @(negedge i_clk);
            #1;
            n_checks++;
            if ({err, busy, w_ready, tap_valid} !== 4'b0000 || wr_count != w0)
                $display("FAIL err_after case%0d got err/busy/wr/tv=%b writes=%0d want 0000 writes=%0d",
                         i, {err, busy, w_ready, tap_valid}, wr_count - w0, 0);
            else n_pass++;
        end
    endtask

    task automatic test_load;
        int k = 0;
        int c = 0;
        int w0 = wr_count;
        start(1'b1, 1'b0, 9, 1);
        while (k < 9 && c < 60) begin
            w_valid = ((c % 3) != 2);
            w_data  = 8'(k + 1);
            #1;
            n_checks++;
            if (w_ready !== 1'b1 || kr_wr_en !== w_valid || busy !== 1'b1)
                $display("FAIL load_hs c%0d got rdy/en/busy=%b%b%b want 1%b1",
                         c, w_ready, kr_wr_en, busy, w_valid);
            else n_pass++;
            if (w_valid) begin
                n_checks++;
                if (kr_wr_addr !== 6'(k) || kr_wr_data !== 8'(k + 1))
                    $display("FAIL load_wr k%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                             k, kr_wr_addr, kr_wr_data, k, k + 1);
                else n_pass++;
                k++;
            end
            c++;
            @(negedge i_clk);
        end
        w_valid = 1'b0;
        #1;
        n_checks++;
        if (k != 9 || {done, busy, w_ready} !== 3'b110)
            $display("FAIL load_done got hs=%0d done/busy/rdy=%b want hs=9 110", k, {done, busy, w_ready});
        else n_pass++;
        @(negedge i_clk);
        #1;
        n_checks++;
        if ({done, busy} !== 2'b00 || wr_count - w0 != 9)
            $display("FAIL load_idle got done/busy=%b writes=%0d want 00 writes=9", {done, busy}, wr_count - w0);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (mem[i] !== 8'(i + 1))
                $display("FAIL load_mem addr%0d got %0d want %0d", i, mem[i], i + 1);
            else n_pass++;
        end
    endtask

    task automatic test_run(input int n, input int p, input bit toggle);
        int k = 0;
        int c = 0;
        start(1'b0, 1'b1, n, p);
        while (k < n * p && c < 400) begin
            tap_ready = toggle ? ((c % 2) == 0) : 1'b1;
            #1;
            n_checks++;
            if (tap_valid !== 1'b1 || kr_rd_addr !== 6'(k % n) ||
                tap_first !== ((k % n) == 0) || tap_last !== ((k % n) == n - 1))
                $display("FAIL run_tap k%0d c%0d got tv=%b addr=%0d first=%b last=%b want 1 addr=%0d first=%b last=%b",
                         k, c, tap_valid, kr_rd_addr, tap_first, tap_last, k % n, (k % n) == 0, (k % n) == n - 1);
            else n_pass++;
            n_checks++;
            if (rd_data !== mem[k % n] || (n == 9 && rd_data !== 8'((k % n) + 1)))
                $display("FAIL run_data k%0d got %0d want %0d", k, rd_data, mem[k % n]);
            else n_pass++;
            if (tap_ready) k++;
            c++;
            @(negedge i_clk);
        end
        tap_ready = 1'b0;
        #1;
        n_checks++;
        if (k != n * p || {done, busy, tap_valid, tap_last} !== 4'b1100)
            $display("FAIL run_done got hs=%0d done/busy/tv/last=%b want hs=%0d 1100",
                     k, {done, busy, tap_valid, tap_last}, n * p);
        else n_pass++;
        @(negedge i_clk);
        #1;
        n_checks++;
        if ({done, busy, err} !== 3'b000)
            $display("FAIL run_idle got done/busy/err=%b want 000", {done, busy, err});
        else n_pass++;
    endtask

    task automatic test_simultaneous;
        int k = 0;
        int c = 0;
        start(1'b1, 1'b1, 9, 1);
        cfg_num_passes = 16'd1;
        run_start = 1'b1;
        #1;
        n_checks++;
        if ({w_ready, tap_valid, busy} !== 3'b101)
            $display("FAIL simul_enter got rdy/tv/busy=%b want 101", {w_ready, tap_valid, busy});
        else n_pass++;
        @(negedge i_clk);
        run_start = 1'b0;
        while (k < 9 && c < 40) begin
            w_valid = 1'b1;
            w_data  = 8'(k + 1);
            #1;
            n_checks++;
            if ({err, tap_valid, w_ready} !== 3'b001 || kr_wr_addr !== 6'(k))
                $display("FAIL simul_load k%0d got err/tv/rdy=%b addr=%0d want 001 addr=%0d",
                         k, {err, tap_valid, w_ready}, kr_wr_addr, k);
            else n_pass++;
            k++;
            c++;
            @(negedge i_clk);
        end
        w_valid = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b1)
            $display("FAIL simul_done got %b want 1", done);
        else n_pass++;
        @(negedge i_clk);
    endtask

    task automatic test_boundary;
        int k = 0;
        start(1'b1, 1'b0, 64, 1);
        while (k < 64) begin
            w_valid = 1'b1;
            w_data  = 8'(k * 3 + 7);
            #1;
            n_checks++;
            if (kr_wr_en !== 1'b1 || kr_wr_addr !== 6'(k) || kr_wr_data !== 8'(k * 3 + 7))
                $display("FAIL bnd_wr k%0d got en=%b addr=%0d data=%0d want 1 addr=%0d data=%0d",
                         k, kr_wr_en, kr_wr_addr, kr_wr_data, k, 8'(k * 3 + 7));
            else n_pass++;
            k++;
            @(negedge i_clk);
        end
        w_valid = 1'b0;
        #1;
        n_checks++;
        if ({done, w_ready} !== 2'b10 || mem[63] !== 8'(63 * 3 + 7))
            $display("FAIL bnd_load_done got done/rdy=%b mem63=%0d want 10 mem63=%0d",
                     {done, w_ready}, mem[63], 8'(63 * 3 + 7));
        else n_pass++;
        @(negedge i_clk);
        test_run(64, 1, 1'b0);
    endtask

    task automatic test_reset_mid;
        int k = 0;
        start(1'b0, 1'b1, 9, 2);
        tap_ready = 1'b1;
        while (k < 5) begin
            @(negedge i_clk);
            k++;
        end
        #1;
        n_checks++;
        if (tap_valid !== 1'b1 || kr_rd_addr !== 6'd5)
            $display("FAIL rst_pre got tv=%b addr=%0d want 1 addr=5", tap_valid, kr_rd_addr);
        else n_pass++;
        i_rst = 1'b1;
        #1;
        n_checks++;
        if ({tap_valid, tap_first, tap_last, busy, done, err} !== 6'b0 || kr_rd_addr !== 6'd0)
            $display("FAIL rst_mid got flags=%b addr=%0d want 000000 addr=0",
                     {tap_valid, tap_first, tap_last, busy, done, err}, kr_rd_addr);
        else n_pass++;
        @(negedge i_clk);
        i_rst     = 1'b0;
        tap_ready = 1'b0;
        start(1'b0, 1'b1, 9, 1);
        #1;
        n_checks++;
        if ({err, busy} !== 2'b10)
            $display("FAIL rst_run_rejected got err/busy=%b want 10", {err, busy});
        else n_pass++;
        @(negedge i_clk);
        start(1'b1, 1'b0, 9, 1);
        k = 0;
        while (k < 9) begin
            w_valid = 1'b1;
            w_data  = 8'(k + 1);
            @(negedge i_clk);
            k++;
        end
        w_valid = 1'b0;
        @(negedge i_clk);
        test_run(9, 1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_errors(0, 2);
        test_load();
        test_run(9, 2, 1'b1);
        test_errors(3, 4);
        test_simultaneous();
        test_boundary();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
